vga_display_ctrl: RTL and testbench

VGA_DISPLAY_CTRL -- requirements
Module: vga_display_ctrl

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_axis_counter.sv | 53 +++++
 rtl/vga_display_ctrl.sv | 163 ++++++++++++++++
 tb/tb_vga_display_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants: default 640x480@60 timing, colour width and the colour-bar table.
package vga_pkg;

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;
  localparam int unsigned DefRgbW    = 12;

  localparam logic [11:0] DefUnderflowRgb = 12'hF0F;

  // One bit per channel, {r, g, b}.
  typedef logic [2:0] rgb3_t;

  // Bar 0 in the low bits: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [23:0] BarTable = {3'b000, 3'b001, 3'b100, 3'b101,
                                      3'b010, 3'b011, 3'b110, 3'b111};

  function automatic rgb3_t bar_rgb3(input logic [2:0] idx);
    return BarTable[32'(idx) * 3 +: 3];
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One VGA timing axis: wrapping counter with registered active-area and sync-window flags.
module vga_axis_counter #(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter int unsigned CNT_W  = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o,
  output logic             active_o,
  output logic             sync_o
);

  localparam int unsigned Total = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] Last = CNT_W'(Total - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             sync_q, sync_d;

  assign wrap_o = en_i && (cnt_q == Last);

  // Flags are decoded from the next count so they stay aligned with cnt_q.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = (cnt_q == Last) ? '0 : cnt_q + 1'b1;
    end
    active_d = 32'(cnt_d) < ACTIVE;
    sync_d   = (32'(cnt_d) >= ACTIVE + FP) && (32'(cnt_d) < ACTIVE + FP + SYNC);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      active_q <= (ACTIVE > 0);
      sync_q   <= (ACTIVE + FP == 0) && (SYNC > 0);
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      sync_q   <= sync_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign active_o = active_q;
  assign sync_o   = sync_q;

endmodule

// File: rtl/vga_display_ctrl.sv
// VGA timing generator with pixel-request handshake and registered colour/sync outputs.
// Define VGA_TEST_PATTERN_EN to build in the 8-bar test pattern selected by test_mode.
module vga_display_ctrl import vga_pkg::*; #(
  parameter int unsigned      CLK_DIV       = 4,
  parameter int unsigned      RGB_W         = DefRgbW,
  parameter int unsigned      H_ACTIVE      = DefHActive,
  parameter int unsigned      H_FP          = DefHFp,
  parameter int unsigned      H_SYNC        = DefHSync,
  parameter int unsigned      H_BP          = DefHBp,
  parameter int unsigned      V_ACTIVE      = DefVActive,
  parameter int unsigned      V_FP          = DefVFp,
  parameter int unsigned      V_SYNC        = DefVSync,
  parameter int unsigned      V_BP          = DefVBp,
  parameter bit               HSYNC_POL     = 1'b0,
  parameter bit               VSYNC_POL     = 1'b0,
  parameter int unsigned      CNT_W         = 10,
  parameter logic [RGB_W-1:0] UNDERFLOW_RGB = RGB_W'(DefUnderflowRgb)
) (
  input  logic             clock_100mhz,
  input  logic             reset,
  input  logic [RGB_W-1:0] pixel_data,
  input  logic             pixel_valid,
  input  logic             test_mode,
  output logic             pix_tick,
  output logic [CNT_W-1:0] pixel_x_out,
  output logic [CNT_W-1:0] pixel_y_out,
  output logic             video_on_out,
  output logic             frame_start,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic [RGB_W-1:0] rgb_out,
  output logic             underflow
);

  localparam logic [3:0] DivLast = 4'(CLK_DIV - 1);

  logic [3:0]       div_q, div_d;
  logic             h_wrap, v_wrap, h_active, v_active, h_sync, v_sync;
  logic [RGB_W-1:0] pix_sel, rgb_q, rgb_d;
  logic             uf_set;
  logic             underflow_q, underflow_d;
  logic             frame_start_q, frame_start_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;

  assign pix_tick = (div_q == DivLast);
  assign div_d    = pix_tick ? '0 : div_q + 4'd1;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .CNT_W  (CNT_W)
  ) u_h_cnt (
    .clk_i    (clock_100mhz),
    .rst_i    (reset),
    .en_i     (pix_tick),
    .cnt_o    (pixel_x_out),
    .wrap_o   (h_wrap),
    .active_o (h_active),
    .sync_o   (h_sync)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .CNT_W  (CNT_W)
  ) u_v_cnt (
    .clk_i    (clock_100mhz),
    .rst_i    (reset),
    .en_i     (h_wrap),
    .cnt_o    (pixel_y_out),
    .wrap_o   (v_wrap),
    .active_o (v_active),
    .sync_o   (v_sync)
  );

  assign video_on_out = h_active & v_active;

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned ChW = RGB_W / 3;

  logic [2:0]       bar_idx;
  rgb3_t            bar3;
  logic [RGB_W-1:0] bar_rgb;

  assign bar_idx = 3'((32'(pixel_x_out) * 8) / H_ACTIVE);
  assign bar3    = bar_rgb3(bar_idx);
  assign bar_rgb = RGB_W'({{ChW{bar3[2]}}, {ChW{bar3[1]}}, {ChW{bar3[0]}}});

  always_comb begin
    pix_sel = '0;
    uf_set  = 1'b0;
    if (video_on_out) begin
      if (test_mode) begin
        pix_sel = bar_rgb;
      end else if (pixel_valid) begin
        pix_sel = pixel_data;
      end else begin
        pix_sel = UNDERFLOW_RGB;
        uf_set  = 1'b1;
      end
    end
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;

  always_comb begin
    pix_sel = '0;
    uf_set  = 1'b0;
    if (video_on_out) begin
      if (pixel_valid) begin
        pix_sel = pixel_data;
      end else begin
        pix_sel = UNDERFLOW_RGB;
        uf_set  = 1'b1;
      end
    end
  end
`endif

  // The presented pixel is resolved on the tick that also advances the counters.
  always_comb begin
    rgb_d         = pix_tick ? pix_sel : rgb_q;
    hsync_d       = pix_tick ? (h_sync ^ ~HSYNC_POL) : hsync_q;
    vsync_d       = pix_tick ? (v_sync ^ ~VSYNC_POL) : vsync_q;
    frame_start_d = v_wrap;
    underflow_d   = underflow_q;
    if (pix_tick && uf_set) begin
      underflow_d = 1'b1;
    end else if (frame_start_d) begin
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      div_q         <= '0;
      rgb_q         <= '0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      underflow_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      underflow_q   <= underflow_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign rgb_out     = rgb_q;
  assign hsync_out   = hsync_q;
  assign vsync_out   = vsync_q;
  assign underflow   = underflow_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_display_ctrl.sv
// Scoreboard bench for vga_display_ctrl on a shrunken raster with randomized pixel data.
module tb_vga_display_ctrl;

  localparam int unsigned D   = 3;
  localparam int unsigned HA  = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int unsigned VA  = 8,  VFP = 1, VS = 2, VBP = 2;
  localparam int unsigned CW  = 6;
  localparam bit          HPOL = 1'b0;
  localparam bit          VPOL = 1'b1;
  localparam int unsigned HT  = HA + HFP + HS + HBP;
  localparam int unsigned VT  = VA + VFP + VS + VBP;
  localparam int unsigned FT  = HT * VT;
  localparam logic [11:0] UF_RGB = 12'hF0F;
`ifdef VGA_TEST_PATTERN_EN
  localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                       12'hF0F, 12'hF00, 12'h00F, 12'h000};
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [11:0]   pixel_data = '0;
  logic          pixel_valid = 1'b0;
  logic          test_mode = 1'b0;
  logic          pix_tick, video_on_out, frame_start, hsync_out, vsync_out, underflow;
  logic [CW-1:0] pixel_x_out, pixel_y_out;
  logic [11:0]   rgb_out;

  always #5 clk = ~clk;

  vga_display_ctrl #(
    .CLK_DIV   (D),
    .RGB_W     (12),
    .H_ACTIVE  (HA),
    .H_FP      (HFP),
    .H_SYNC    (HS),
    .H_BP      (HBP),
    .V_ACTIVE  (VA),
    .V_FP      (VFP),
    .V_SYNC    (VS),
    .V_BP      (VBP),
    .HSYNC_POL (HPOL),
    .VSYNC_POL (VPOL),
    .CNT_W     (CW)
  ) dut (
    .clock_100mhz (clk),
    .reset        (reset),
    .pixel_data   (pixel_data),
    .pixel_valid  (pixel_valid),
    .test_mode    (test_mode),
    .pix_tick     (pix_tick),
    .pixel_x_out  (pixel_x_out),
    .pixel_y_out  (pixel_y_out),
    .video_on_out (video_on_out),
    .frame_start  (frame_start),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .rgb_out      (rgb_out),
    .underflow    (underflow)
  );

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } out_t;

  out_t        exp_q[$];
  int unsigned k, m, cur_x, cur_y, miss_pct;
  bit          mdl_rst = 1'b1;
  bit          e_tick, e_fs, e_uf, pend_uf;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Reference: what one presented pixel must produce one pixel period later.
  function automatic out_t ref_out(int unsigned x, int unsigned y, bit valid,
                                   logic [11:0] data, bit tm);
    out_t o;
    bit   von;
    von  = (x < HA) && (y < VA);
    o.hs = (x >= HA + HFP && x < HA + HFP + HS) ? HPOL : !HPOL;
    o.vs = (y >= VA + VFP && y < VA + VFP + VS) ? VPOL : !VPOL;
    if (!von) o.rgb = '0;
`ifdef VGA_TEST_PATTERN_EN
    else if (tm) o.rgb = BARS[x * 8 / HA];
`endif
    else if (valid) o.rgb = data;
    else o.rgb = UF_RGB;
    return o;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t (model x=%0d y=%0d): got %0h expected %0h",
               name, $time, cur_x, cur_y, act, exp);
    end
  endtask

  task automatic present();
    logic [11:0] d;
    bit          v, tm;
    d  = 12'($urandom);
    v  = ($urandom_range(99) >= miss_pct);
    tm = ($urandom_range(3) == 0);
    pixel_data  = d;
    pixel_valid = v;
    test_mode   = tm;
    exp_q.push_back(ref_out(cur_x, cur_y, v, d, tm));
    pend_uf = (cur_x < HA) && (cur_y < VA) && !v;
`ifdef VGA_TEST_PATTERN_EN
    if (tm) pend_uf = 1'b0;
`endif
  endtask

  // Advance the model by one clock edge, then present new data after a tick edge.
  task automatic step();
    @(posedge clk);
    mdl_rst = reset;
    if (reset) begin
      k = 0; m = 0; cur_x = 0; cur_y = 0;
      e_tick = 0; e_fs = 0; e_uf = 0; pend_uf = 0;
      exp_q.delete();
    end else begin
      k++;
      e_fs = 0;
      if (k % D == 0) begin
        m++;
        cur_x = (m % FT) % HT;
        cur_y = (m % FT) / HT;
        e_fs  = (m % FT == 0);
        e_uf  = pend_uf ? 1'b1 : (e_fs ? 1'b0 : e_uf);
      end
      e_tick = (k % D == D - 1);
    end
    #1;
    if (!mdl_rst && k % D == 0) present();
  endtask

  task automatic apply_reset(int unsigned n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
    present();
  endtask

  // Monitor: pops one expectation per DUT pixel tick, checks everything every cycle.
  initial begin
    out_t held;
    bit   prev_tick;
    held      = out_t'{rgb: 12'h000, hs: !HPOL, vs: !VPOL};
    prev_tick = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (mdl_rst) begin
        held = out_t'{rgb: 12'h000, hs: !HPOL, vs: !VPOL};
      end else if (prev_tick) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scoreboard_empty at %0t: got 0 entries expected >=1", $time);
        end else begin
          held = exp_q.pop_front();
        end
      end
      chk("pix_tick", 32'(pix_tick), 32'(e_tick));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
      chk("pixel_x_out", 32'(pixel_x_out), cur_x);
      chk("pixel_y_out", 32'(pixel_y_out), cur_y);
      chk("video_on_out", 32'(video_on_out), 32'((cur_x < HA) && (cur_y < VA)));
      chk("underflow", 32'(underflow), 32'(e_uf));
      chk("rgb_out", 32'(rgb_out), 32'(held.rgb));
      chk("hsync_out", 32'(hsync_out), 32'(held.hs));
      chk("vsync_out", 32'(vsync_out), 32'(held.vs));
      prev_tick = pix_tick;
    end
  end

  initial begin
    miss_pct = 6;
    apply_reset(3);
    repeat (4 * FT * D) step();
    // Clean frames: underflow must clear at frame_start and stay clear.
    miss_pct = 0;
    repeat (2 * FT * D + 37) step();
    // Mid-frame reset, then heavy underflow traffic.
    miss_pct = 30;
    repeat (FT * D / 2 + 5) step();
    apply_reset(3);
    repeat (2 * FT * D) step();
    for (int i = 0; i < 4; i++) begin
      miss_pct = $urandom_range(20);
      repeat ($urandom_range(FT * D)) step();
      apply_reset(1 + $urandom_range(3));
      repeat (FT * D + $urandom_range(50)) step();
    end
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
